// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared board-level types and constants.
//   rst_state_t    : reset sequencer states (WAIT_LOCK, RUN)
//   BOARD_KEYS_W   : default number of key inputs on the board tops
//   BOARD_LEDS_W   : default number of LED outputs on the board tops
// -----------------------------------------------------------------------------
package board_pkg;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } rst_state_t;

  localparam int BOARD_KEYS_W = 2;
  localparam int BOARD_LEDS_W = 6;

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One key: pad synchroniser, polarity fix, debounce counter, debounced level
// and one-cycle press/release pulses.
// Ports:
//   clk_i       in  : clock
//   rst_n_i     in  : asynchronous active-low reset
//   clr_i       in  : hold level, counter and pulses at 0 (game reset active)
//   key_raw_i   in  : raw key pad
//   key_o       out : debounced level, 1 = pressed
//   pressed_o   out : one-cycle pulse on accepted press
//   released_o  out : one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module key_debounce
  import board_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 252000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic key_raw_i,
  output logic key_o,
  output logic pressed_o,
  output logic released_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_key;
  logic                   r_pressed;
  logic                   r_released;
  logic                   w_k_s;

  // The synchroniser resets to the idle pad level so that leaving reset
  // never looks like a key edge. It keeps running while clr_i is high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= {SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], key_raw_i};
    end
  end

  assign w_k_s = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt      <= '0;
      r_key      <= 1'b0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
    end else if (clr_i) begin
      r_cnt      <= '0;
      r_key      <= 1'b0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      if (w_k_s == r_key) begin
        // Any return to the accepted level restarts the stability window.
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_key      <= w_k_s;
        r_cnt      <= '0;
        r_pressed  <= w_k_s;
        r_released <= ~w_k_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign key_o      = r_key;
  assign pressed_o  = r_pressed;
  assign released_o = r_released;

endmodule

// File: rtl/board_io_ctrl.sv
// -----------------------------------------------------------------------------
// board_io_ctrl
// Board reset sequencer and I/O conditioner between pins/PLL and game_top.
// Ports:
//   clk_i            in  : pixel clock
//   rst_n_i          in  : asynchronous active-low board button reset
//   pll_lock_i       in  : PLL lock, asynchronous to clk_i
//   keys_raw_i       in  : raw key pads
//   leds_i           in  : LED requests from the game, 1 = on
//   rst_o            out : synchronous active-high reset to game logic
//   keys_o           out : debounced key levels, 1 = pressed
//   keys_pressed_o   out : one-cycle pulses on accepted presses
//   keys_released_o  out : one-cycle pulses on accepted releases
//   leds_o           out : LED pads with polarity applied
// -----------------------------------------------------------------------------
module board_io_ctrl
  import board_pkg::*;
#(
  parameter int KEYS_W          = BOARD_KEYS_W,
  parameter int LEDS_W          = BOARD_LEDS_W,
  parameter bit KEYS_ACTIVE_LOW = 1'b1,
  parameter bit LEDS_ACTIVE_LOW = 1'b1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 252000,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              pll_lock_i,
  input  logic [KEYS_W-1:0] keys_raw_i,
  input  logic [LEDS_W-1:0] leds_i,
  output logic              rst_o,
  output logic [KEYS_W-1:0] keys_o,
  output logic [KEYS_W-1:0] keys_pressed_o,
  output logic [KEYS_W-1:0] keys_released_o,
  output logic [LEDS_W-1:0] leds_o
);

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [LEDS_W-1:0] LEDS_OFF  = {LEDS_W{LEDS_ACTIVE_LOW}};

  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic                   w_lock_s;
  rst_state_t             r_state;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic                   r_rst;
  logic [LEDS_W-1:0]      r_leds;

  // PLL lock synchroniser.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lock_sync <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

  // Reset sequencer: lock must be seen continuously for RST_HOLD_CYCLES
  // before the game leaves reset; any drop restarts the count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= WAIT_LOCK;
      r_hold_cnt <= '0;
      r_rst      <= 1'b1;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          r_rst <= 1'b1;
          if (!w_lock_s) begin
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= RUN;
            r_hold_cnt <= '0;
            r_rst      <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        RUN: begin
          r_rst      <= 1'b0;
          r_hold_cnt <= '0;
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_rst   <= 1'b1;
          end
        end
        default: begin
          r_state    <= WAIT_LOCK;
          r_hold_cnt <= '0;
          r_rst      <= 1'b1;
        end
      endcase
    end
  end

  assign rst_o = r_rst;

  // LED pads: registered polarity conversion, dark while the game is reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_leds <= LEDS_OFF;
    end else if (r_rst) begin
      r_leds <= LEDS_OFF;
    end else begin
      r_leds <= leds_i ^ LEDS_OFF;
    end
  end

  assign leds_o = r_leds;

  genvar gi;
  generate
    for (gi = 0; gi < KEYS_W; gi++) begin : g_key
      key_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (KEYS_ACTIVE_LOW)
      ) u_key (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clr_i      (r_rst),
        .key_raw_i  (keys_raw_i[gi]),
        .key_o      (keys_o[gi]),
        .pressed_o  (keys_pressed_o[gi]),
        .released_o (keys_released_o[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_board_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_board_io_ctrl
// Scoreboard bench: stimulus pushes expected events (reset edges, key pulses)
// with the cycle they must appear in; a monitor pops and compares whenever
// the DUT shows one. A few levels are also compared directly.
// -----------------------------------------------------------------------------
module tb_board_io_ctrl;

  localparam int KW = 2;
  localparam int LW = 6;

  localparam int K_RST_FALL = 0;
  localparam int K_RST_RISE = 1;
  localparam int K_PRESS    = 2;
  localparam int K_RELEASE  = 3;

  logic          clk_i      = 1'b0;
  logic          rst_n_i    = 1'b1;
  logic          pll_lock_i = 1'b1;
  logic [KW-1:0] keys_raw_i = 2'b11;
  logic [LW-1:0] leds_i     = 6'b111111;
  logic          rst_o;
  logic [KW-1:0] keys_o;
  logic [KW-1:0] keys_pressed_o;
  logic [KW-1:0] keys_released_o;
  logic [LW-1:0] leds_o;

  board_io_ctrl #(
    .KEYS_W          (KW),
    .LEDS_W          (LW),
    .KEYS_ACTIVE_LOW (1'b1),
    .LEDS_ACTIVE_LOW (1'b1),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RST_HOLD_CYCLES (8)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .pll_lock_i      (pll_lock_i),
    .keys_raw_i      (keys_raw_i),
    .leds_i          (leds_i),
    .rst_o           (rst_o),
    .keys_o          (keys_o),
    .keys_pressed_o  (keys_pressed_o),
    .keys_released_o (keys_released_o),
    .leds_o          (leds_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int idx;
    int at;
  } ev_t;

  ev_t   exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  bit    mon_en   = 1'b0;
  logic  prev_rst = 1'b1;
  string kname[4] = '{"rst_fall", "rst_rise", "press", "release"};

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) begin
      n_pass++;
      $display("check %s ok: %0d", name, act);
    end else begin
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic exp_ev(input int kind, input int idx, input int at);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input int idx);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL event: got %s[%0d]@%0d, required none", kname[kind], idx, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind == kind && e.idx == idx && e.at == cyc) begin
      n_pass++;
      $display("event %s[%0d]@%0d ok", kname[kind], idx, cyc);
    end else begin
      $display("FAIL event: got %s[%0d]@%0d, required %s[%0d]@%0d",
               kname[kind], idx, cyc, kname[e.kind], e.idx, e.at);
    end
  endtask

  // Monitor: every negedge, turn DUT output activity into events.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (rst_o !== prev_rst) got_ev(rst_o ? K_RST_RISE : K_RST_FALL, 0);
      prev_rst = rst_o;
      for (int k = 0; k < KW; k++) begin
        if (keys_pressed_o[k]) begin
          got_ev(K_PRESS, k);
          chk("level_at_press", int'(keys_o[k]), 1);
        end
      end
      for (int k = 0; k < KW; k++) begin
        if (keys_released_o[k]) begin
          got_ev(K_RELEASE, k);
          chk("level_at_release", int'(keys_o[k]), 0);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    int c;
    #1 rst_n_i = 1'b0;
    step(3);
    chk("rst_o_in_reset", int'(rst_o), 1);
    chk("keys_o_in_reset", int'(keys_o), 0);
    chk("pressed_in_reset", int'(keys_pressed_o), 0);
    chk("released_in_reset", int'(keys_released_o), 0);
    chk("leds_off_in_reset", int'(leds_o), 6'h3F);
    mon_en = 1'b1;

    // Release with lock held: 2 sync + 8 hold cycles.
    rst_n_i = 1'b1;
    exp_ev(K_RST_FALL, 0, cyc + 10);
    step(14);
    chk("leds_run_all_on", int'(leds_o), 6'h00);

    // Lock drop while running: 2 sync cycles, then registered rst_o.
    pll_lock_i = 1'b0;
    exp_ev(K_RST_RISE, 0, cyc + 3);
    step(8);

    // Lock back, 5 cycles, 1-cycle glitch: full hold count restarts.
    pll_lock_i = 1'b1;
    c = cyc;
    exp_ev(K_RST_FALL, 0, c + 16);
    step(5);
    pll_lock_i = 1'b0;
    step(1);
    pll_lock_i = 1'b1;
    step(14);

    // Clean press and release on key 0.
    keys_raw_i[0] = 1'b0;
    exp_ev(K_PRESS, 0, cyc + 6);
    step(10);
    chk("keys_o_key0_held", int'(keys_o), 2'b01);
    keys_raw_i[0] = 1'b1;
    exp_ev(K_RELEASE, 0, cyc + 6);
    step(10);

    // Bounce 0,1,0,1,0 on key 1, then held.
    keys_raw_i[1] = 1'b0; step(1);
    keys_raw_i[1] = 1'b1; step(1);
    keys_raw_i[1] = 1'b0; step(1);
    keys_raw_i[1] = 1'b1; step(1);
    keys_raw_i[1] = 1'b0;
    exp_ev(K_PRESS, 1, cyc + 6);
    step(10);
    keys_raw_i[1] = 1'b1;
    exp_ev(K_RELEASE, 1, cyc + 6);
    step(10);

    // Both keys together.
    keys_raw_i = 2'b00;
    exp_ev(K_PRESS, 0, cyc + 6);
    exp_ev(K_PRESS, 1, cyc + 6);
    step(10);
    chk("keys_o_both_held", int'(keys_o), 2'b11);
    keys_raw_i = 2'b11;
    exp_ev(K_RELEASE, 0, cyc + 6);
    exp_ev(K_RELEASE, 1, cyc + 6);
    step(10);

    // LED polarity, one cycle latency.
    leds_i = 6'b000101;
    step(1);
    chk("leds_polarity", int'(leds_o), 6'b111010);

    // Press key 0 and keep it held through an asynchronous reset.
    keys_raw_i[0] = 1'b0;
    exp_ev(K_PRESS, 0, cyc + 6);
    step(8);
    #2 rst_n_i = 1'b0;
    #1;
    chk("async_rst_o", int'(rst_o), 1);
    chk("async_keys_o", int'(keys_o), 0);
    chk("async_leds_off", int'(leds_o), 6'h3F);
    exp_ev(K_RST_RISE, 0, cyc + 1);
    step(4);

    // Release reset with key 0 still held: press 4 cycles after rst_o falls.
    rst_n_i = 1'b1;
    c = cyc;
    exp_ev(K_RST_FALL, 0, c + 10);
    exp_ev(K_PRESS, 0, c + 14);
    step(18);
    keys_raw_i[0] = 1'b1;
    exp_ev(K_RELEASE, 0, cyc + 6);
    step(10);

    chk("events_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
